// File: rtl/vend_motor_driver.sv
// vend_motor_driver: steps one of two 4-coil unipolar steppers for a vend.
// A go pulse with a valid code runs the selected motor a fixed number of
// step phases, holds the final coil pattern, then de-energises and pulses done.
// Optional macro VEND_HALF_STEP_EN selects an 8-phase half-step sequence
// in place of the default 4-phase wave drive.
module vend_motor_driver #(
  parameter int STEP_DIV       = 250000,
  parameter int STEPS_PER_VEND = 512,
  parameter int HOLD_CYC       = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [1:0] code,
  input  logic       abort,
  output logic [7:0] coils,
  output logic       busy,
  output logic       done,
  output logic       err
);

`ifdef VEND_HALF_STEP_EN
  localparam int NUM_PHASES = 2 * STEPS_PER_VEND;
  localparam int PH_W       = 3;
`else
  localparam int NUM_PHASES = STEPS_PER_VEND;
  localparam int PH_W       = 2;
`endif

  // One down-counter serves as step prescaler in RUN and hold timer in HOLD.
  localparam int CNT_MAX = (STEP_DIV > HOLD_CYC) ? STEP_DIV : HOLD_CYC;
  localparam int PW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(NUM_PHASES + 1);

  localparam logic [PW-1:0] STEP_RELOAD = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] HOLD_RELOAD = PW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] LAST_STEP   = SW'(NUM_PHASES - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   step_q,  step_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            sel_q,   sel_d;
  logic [7:0]      coils_q, coils_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            err_q,   err_d;

  // Coil pattern for a given phase index, coil A in bit 0.
  function automatic logic [3:0] phase_pat(input logic [PH_W-1:0] ph);
    logic [3:0] p;
`ifdef VEND_HALF_STEP_EN
    case (ph)
      3'd0:    p = 4'b0001;
      3'd1:    p = 4'b0011;
      3'd2:    p = 4'b0010;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0100;
      3'd5:    p = 4'b1100;
      3'd6:    p = 4'b1000;
      default: p = 4'b1001;
    endcase
`else
    case (ph)
      2'd0:    p = 4'b0001;
      2'd1:    p = 4'b0010;
      2'd2:    p = 4'b0100;
      default: p = 4'b1000;
    endcase
`endif
    return p;
  endfunction

  // Route a nibble pattern to the selected motor; the other motor stays off.
  function automatic logic [7:0] place(input logic sel, input logic [3:0] pat);
    return sel ? {pat, 4'h0} : {4'h0, pat};
  endfunction

  // Next-state and registered-output computation for the vend sequencer.
  always_comb begin
    logic [PH_W-1:0] ph_nx;
    ph_nx   = phase_q + PH_W'(1);
    state_d = state_q;
    presc_d = presc_q;
    step_d  = step_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    coils_d = coils_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        coils_d = 8'h00;
        busy_d  = 1'b0;
        if (go && !abort) begin
          if (code < 2'd2) begin
            sel_d   = code[0];
            phase_d = '0;
            step_d  = '0;
            presc_d = STEP_RELOAD;
            coils_d = place(code[0], phase_pat('0));
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          coils_d = 8'h00;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (presc_q == '0) begin
          step_d = step_q + SW'(1);
          if (step_q == LAST_STEP) begin
            presc_d = HOLD_RELOAD;
            state_d = HOLD;
          end else begin
            presc_d = STEP_RELOAD;
            phase_d = ph_nx;
            coils_d = place(sel_q, phase_pat(ph_nx));
          end
        end else begin
          presc_d = presc_q - PW'(1);
        end
      end
      HOLD: begin
        if (abort) begin
          coils_d = 8'h00;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (presc_q == '0) begin
          coils_d = 8'h00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          presc_d = presc_q - PW'(1);
        end
      end
      default: begin
        coils_d = 8'h00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      step_q  <= '0;
      phase_q <= '0;
      sel_q   <= 1'b0;
      coils_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
      coils_q <= coils_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign coils = coils_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_vend_motor_driver.sv
// Directed bench for vend_motor_driver with small timing parameters.
module tb_vend_motor_driver;

  localparam int SD  = 4;
  localparam int SPV = 8;
  localparam int HC  = 3;
`ifdef VEND_HALF_STEP_EN
  localparam int SEQ_LEN = 8;
  localparam int NPH     = 2 * SPV;
`else
  localparam int SEQ_LEN = 4;
  localparam int NPH     = SPV;
`endif
  localparam int RUN_CYC  = NPH * SD;
  localparam int DONE_CYC = 1 + RUN_CYC + HC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic [1:0] code = 2'd0;
  logic       abort = 1'b0;
  logic [7:0] coils;
  logic       busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] seq [8];

  vend_motor_driver #(.STEP_DIV(SD), .STEPS_PER_VEND(SPV), .HOLD_CYC(HC)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .code(code), .abort(abort),
    .coils(coils), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] place(input logic [1:0] c, input logic [3:0] p);
    return c[0] ? {p, 4'h0} : {4'h0, p};
  endfunction

  task automatic test_reset();
    #3;
    n_cmp++;
    if (coils !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: coils=%h busy=%b done=%b err=%b, required 00/0/0/0", coils, busy, done, err);
    end
    @(posedge clk);
    #7 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (coils !== 8'h00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: coils=%h busy=%b, required 00/0", coils, busy);
    end
  endtask

  // Pulses go with code c0 in the current cycle, then checks every cycle.
  // go_cyc: cycle in which a stray go (code=1) is pulsed; ab_cyc: abort cycle.
  task automatic run_vend(input logic [1:0] c0, input int go_cyc, input int ab_cyc, input string nm);
    int last;
    logic [7:0] ec;
    logic eb, ed;
    last = (ab_cyc > 0) ? ab_cyc + 4 : DONE_CYC + 1;
    code = c0;
    go = 1'b1;
    tick();
    go = 1'b0;
    code = 2'd3;
    for (int c = 1; c <= last; c++) begin
      eb = 1'b0; ed = 1'b0; ec = 8'h00;
      if (ab_cyc > 0 && c > ab_cyc) begin
        eb = 1'b0;
      end else if (c <= RUN_CYC) begin
        eb = 1'b1;
        ec = place(c0, seq[((c - 1) / SD) % SEQ_LEN]);
      end else if (c <= RUN_CYC + HC) begin
        eb = 1'b1;
        ec = place(c0, seq[(NPH - 1) % SEQ_LEN]);
      end else if (c == DONE_CYC) begin
        ed = 1'b1;
      end
      n_cmp++;
      if (coils !== ec || busy !== eb || done !== ed || err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s cyc%0d: coils=%h busy=%b done=%b err=%b, required %h/%b/%b/0",
                 nm, c, coils, busy, done, err, ec, eb, ed);
      end
      go = (c == go_cyc);
      if (c == go_cyc) code = 2'd1;
      abort = (c == ab_cyc);
      tick();
    end
    go = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_invalid();
    for (int k = 2; k <= 3; k++) begin
      code = 2'(k);
      go = 1'b1;
      tick();
      go = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0 || coils !== 8'h00 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL invalid_code%0d: err=%b busy=%b coils=%h done=%b, required 1/0/00/0", k, err, busy, coils, done);
      end
      tick();
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL invalid_code%0d_clear: err=%b busy=%b, required 0/0", k, err, busy);
      end
    end
    code = 2'd2; go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL go_abort_invalid: err=%b, required 0", err);
    end
    code = 2'd0; go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || coils !== 8'h00) begin
      n_bad++;
      $display("FAIL go_abort_valid: busy=%b coils=%h, required 0/00", busy, coils);
    end
  endtask

  task automatic test_async_reset();
    code = 2'd0; go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (coils !== 8'h00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: coils=%h busy=%b, required 00/0", coils, busy);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (coils !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL async_reset_idle%0d: coils=%h busy=%b done=%b, required 00/0/0", i, coils, busy, done);
      end
    end
  endtask

  initial begin
`ifdef VEND_HALF_STEP_EN
    seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0010; seq[3] = 4'b0110;
    seq[4] = 4'b0100; seq[5] = 4'b1100; seq[6] = 4'b1000; seq[7] = 4'b1001;
`else
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    seq[4] = 4'b0001; seq[5] = 4'b0010; seq[6] = 4'b0100; seq[7] = 4'b1000;
`endif
    test_reset();
    run_vend(2'd0, 0, 0, "motor0");
    run_vend(2'd1, 0, 0, "motor1");
    test_invalid();
    run_vend(2'd0, 10, 0, "go_while_busy");
    run_vend(2'd0, 0, 15, "abort");
    run_vend(2'd0, 0, 0, "restart_after_abort");
    run_vend(2'd1, 0, 0, "back_to_back");
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
